// File: rtl/softex_tcdm_lane_splitter_if.sv
// Bus bundle between the softex wide HCI master, the lane splitter and the MP 64-bit TCDM ports.
// Suffixes are named from the splitter's side: slave is the splitter, master is its environment.
interface softex_tcdm_lane_splitter_if #(
    parameter int unsigned MP = 4,
    parameter int unsigned IW = 8
);
    logic               w_req_i;
    logic               w_gnt_o;
    logic [31:0]        w_add_i;
    logic               w_wen_i;
    logic [MP*8-1:0]    w_be_i;
    logic [MP*64-1:0]   w_data_i;
    logic [IW-1:0]      w_id_i;
    logic               w_r_ready_i;
    logic               w_r_valid_o;
    logic [MP*64-1:0]   w_r_data_o;
    logic [IW-1:0]      w_r_id_o;

    logic [MP-1:0]      n_req_o;
    logic [MP-1:0]      n_gnt_i;
    logic [MP*32-1:0]   n_add_o;
    logic [MP-1:0]      n_wen_o;
    logic [MP*8-1:0]    n_be_o;
    logic [MP*64-1:0]   n_data_o;
    logic [MP*IW-1:0]   n_id_o;
    logic [MP-1:0]      n_r_ready_o;
    logic [MP-1:0]      n_r_valid_i;
    logic [MP*64-1:0]   n_r_data_i;

    modport slave (
        input  w_req_i, w_add_i, w_wen_i, w_be_i, w_data_i, w_id_i, w_r_ready_i,
        output w_gnt_o, w_r_valid_o, w_r_data_o, w_r_id_o,
        output n_req_o, n_add_o, n_wen_o, n_be_o, n_data_o, n_id_o, n_r_ready_o,
        input  n_gnt_i, n_r_valid_i, n_r_data_i
    );

    modport master (
        output w_req_i, w_add_i, w_wen_i, w_be_i, w_data_i, w_id_i, w_r_ready_i,
        input  w_gnt_o, w_r_valid_o, w_r_data_o, w_r_id_o,
        input  n_req_o, n_add_o, n_wen_o, n_be_o, n_data_o, n_id_o, n_r_ready_o,
        output n_gnt_i, n_r_valid_i, n_r_data_i
    );
endinterface

// File: rtl/softex_tcdm_lane_splitter.sv
// Splits a wide HCI TCDM request into MP 64-bit lane requests with independent grants, and
// reassembles per-lane responses in order. Optional protocol checker: SOFTEX_TCDM_LANE_SPLITTER_ERR_EN.
module softex_tcdm_lane_splitter #(
    parameter int unsigned MP          = 4,
    parameter int unsigned LANE_STRIDE = 32,
    parameter int unsigned DEPTH       = 2,
    parameter int unsigned IW          = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      clear_i,
    softex_tcdm_lane_splitter_if.slave bus,
    output logic                      err_o
);
    localparam int unsigned   CW      = $clog2(DEPTH + 1);
    localparam int unsigned   PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LastPtr = PW'(DEPTH - 1);
    localparam logic [CW-1:0] Full    = CW'(DEPTH);

    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] ptr);
        return (ptr == LastPtr) ? '0 : ptr + PW'(1);
    endfunction

    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [MP-1:0] done_q, done_d;
    logic          clearWin_q;
    logic          canIssue, wGnt, wRValid, wPop, dropResp;
    logic [MP-1:0] laneReq, laneFire, lanePush, laneNotEmpty;

    logic [63:0]   laneMem_q [MP][DEPTH];
    logic [PW-1:0] laneWr_q  [MP];
    logic [PW-1:0] laneRd_q  [MP];
    logic [CW-1:0] laneCnt_q [MP];

    logic [IW-1:0] idMem_q [DEPTH];
    logic [PW-1:0] idWr_q, idRd_q;

    // Responses in the clear cycle and the one after belong to a flushed transaction and are discarded.
    always_comb begin
        laneNotEmpty = '0;
        lanePush     = '0;
        canIssue     = outstanding_q < Full;
        laneReq      = {MP{bus.w_req_i & canIssue}} & ~done_q;
        laneFire     = laneReq & bus.n_gnt_i;
        wGnt         = bus.w_req_i & canIssue & (&(done_q | laneFire));
        for (int i = 0; i < MP; i++) begin
            laneNotEmpty[i] = laneCnt_q[i] != '0;
        end
        wRValid  = &laneNotEmpty;
        wPop     = wRValid & bus.w_r_ready_i;
        dropResp = clear_i | clearWin_q;
        for (int i = 0; i < MP; i++) begin
            lanePush[i] = bus.n_r_valid_i[i] & ~dropResp & ((laneCnt_q[i] != Full) | wPop);
        end
        done_d        = (clear_i | ~bus.w_req_i | wGnt) ? '0 : (done_q | laneFire);
        outstanding_d = outstanding_q + CW'(wGnt) - CW'(wPop);
    end

    // Lane i's byte-enable and data slices sit at the same bit positions as on the wide port.
    always_comb begin
        bus.n_req_o     = laneReq;
        bus.w_gnt_o     = wGnt;
        bus.n_r_ready_o = '1;
        bus.n_be_o      = bus.w_be_i;
        bus.n_data_o    = bus.w_data_i;
        bus.w_r_valid_o = wRValid;
        bus.w_r_id_o    = idMem_q[idRd_q];
        bus.n_add_o     = '0;
        bus.n_wen_o     = '0;
        bus.n_id_o      = '0;
        bus.w_r_data_o  = '0;
        for (int i = 0; i < MP; i++) begin
            bus.n_add_o[32*i +: 32]   = bus.w_add_i + 32'(i * LANE_STRIDE);
            bus.n_wen_o[i]            = bus.w_wen_i;
            bus.n_id_o[IW*i +: IW]    = bus.w_id_i;
            bus.w_r_data_o[64*i +: 64] = laneMem_q[i][laneRd_q[i]];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding_q <= '0;
            done_q        <= '0;
            clearWin_q    <= 1'b0;
        end else begin
            clearWin_q    <= clear_i;
            done_q        <= done_d;
            outstanding_q <= clear_i ? '0 : outstanding_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idWr_q  <= '0;
            idRd_q  <= '0;
            idMem_q <= '{default: '0};
        end else if (clear_i) begin
            idWr_q <= '0;
            idRd_q <= '0;
        end else begin
            if (wGnt) begin
                idMem_q[idWr_q] <= bus.w_id_i;
                idWr_q          <= nextPtr(idWr_q);
            end
            if (wPop) begin
                idRd_q <= nextPtr(idRd_q);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            laneMem_q <= '{default: '0};
            for (int i = 0; i < MP; i++) begin
                laneWr_q[i]  <= '0;
                laneRd_q[i]  <= '0;
                laneCnt_q[i] <= '0;
            end
        end else if (clear_i) begin
            for (int i = 0; i < MP; i++) begin
                laneWr_q[i]  <= '0;
                laneRd_q[i]  <= '0;
                laneCnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < MP; i++) begin
                if (lanePush[i]) begin
                    laneMem_q[i][laneWr_q[i]] <= bus.n_r_data_i[64*i +: 64];
                    laneWr_q[i]               <= nextPtr(laneWr_q[i]);
                end
                if (wPop) begin
                    laneRd_q[i] <= nextPtr(laneRd_q[i]);
                end
                laneCnt_q[i] <= laneCnt_q[i] + CW'(lanePush[i]) - CW'(wPop);
            end
        end
    end

`ifdef SOFTEX_TCDM_LANE_SPLITTER_ERR_EN
    logic [CW-1:0] lanePend_q [MP];
    logic [CW-1:0] lanePend_d [MP];
    logic          errSet, err_q;

    // A lane answer with nothing pending, or one that lands on a full FIFO, is a protocol violation.
    always_comb begin
        errSet = 1'b0;
        for (int i = 0; i < MP; i++) begin
            lanePend_d[i] = lanePend_q[i];
            if (bus.n_r_valid_i[i] && !dropResp) begin
                if (lanePend_q[i] == '0) begin
                    errSet = 1'b1;
                end else begin
                    lanePend_d[i] = lanePend_q[i] - CW'(1);
                end
                if ((laneCnt_q[i] == Full) && !wPop) begin
                    errSet = 1'b1;
                end
            end
            if (laneFire[i]) begin
                lanePend_d[i] = lanePend_d[i] + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
            for (int i = 0; i < MP; i++) lanePend_q[i] <= '0;
        end else if (clear_i) begin
            err_q <= 1'b0;
            for (int i = 0; i < MP; i++) lanePend_q[i] <= '0;
        end else begin
            err_q <= err_q | errSet;
            for (int i = 0; i < MP; i++) lanePend_q[i] <= lanePend_d[i];
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: doc/softex_tcdm_lane_splitter.md
Name: softex_tcdm_lane_splitter

Overview:
- Sits between the softex accelerator's wide HCI TCDM master port (DW = MP*64) and the MP independent 64-bit TCDM cluster ports.
- Splits each wide request into MP lane requests and tracks the grant of each lane independently, instead of requiring all grants in the same cycle.
- Buffers each lane's responses and reassembles them into one in-order wide response, so lanes that are granted or answered out of step never drop or misalign data.

Parameters:
- MP, 4, number of 64-bit lanes.
- LANE_STRIDE, 32, byte address offset between consecutive lanes.
- DEPTH, 2, maximum outstanding wide transactions; also the depth of each lane response FIFO and of the ID FIFO.
- IW, 8, transaction ID width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset.
- clear_i  in  1  synchronous flush.
- w_req_i  in  1  wide request.
- w_gnt_o  out  1  wide grant.
- w_add_i  in  32  wide byte address.
- w_wen_i  in  1  1 = read, 0 = write.
- w_be_i  in  MP*8  byte enables.
- w_data_i  in  MP*64  write data.
- w_id_i  in  IW  request ID.
- w_r_ready_i  in  1  wide response ready.
- w_r_valid_o  out  1  wide response valid.
- w_r_data_o  out  MP*64  read data.
- w_r_id_o  out  IW  response ID.
- n_req_o  out  MP  lane request.
- n_gnt_i  in  MP  lane grant.
- n_add_o  out  MP*32  lane address.
- n_wen_o  out  MP  lane wen.
- n_be_o  out  MP*8  lane byte enables.
- n_data_o  out  MP*64  lane write data.
- n_id_o  out  MP*IW  lane ID.
- n_r_ready_o  out  MP  lane response ready.
- n_r_valid_i  in  MP  lane response valid.
- n_r_data_i  in  MP*64  lane read data.
- err_o  out  1  sticky protocol error.

Behaviour:
- Reset: rst_ni, asynchronous, active-low; clock clk_i. All state clears: done bits, outstanding counter, all FIFOs, err_o. After reset, w_gnt_o = 0, w_r_valid_o = 0, n_req_o = 0, n_r_ready_o = all 1.
- Lane field mapping, combinational from the wide inputs:
  - n_add_o[i] = w_add_i + i*LANE_STRIDE, mod 2^32.
  - n_be_o[i] = w_be_i[8i+7:8i].
  - n_data_o[i] = w_data_i[64i+63:64i].
  - n_wen_o[i] = w_wen_i; n_id_o[i] = w_id_i.
- Credit gate: can_issue = (outstanding < DEPTH).
- Lane requests: n_req_o[i] = w_req_i & can_issue & ~done[i].
- Done bits: done[i] sets on n_req_o[i] & n_gnt_i[i]. A granted lane drops its request the next cycle. Done bits clear when w_gnt_o fires, when w_req_i = 0, or on clear_i.
- Wide grant: w_gnt_o = w_req_i & can_issue & &(done | (n_req_o & n_gnt_i)). This is combinational, so all-lanes-granted in the same cycle gives a zero-latency grant.
- Upstream rule: upstream holds all w_* request fields stable while w_req_i = 1 and w_gnt_o = 0.
- ID tracking: at w_gnt_o, w_id_i is pushed into the ID FIFO.
- Outstanding counter: +1 on w_gnt_o, -1 on wide pop. Both in the same cycle leaves it unchanged. Range is 0..DEPTH.
- Response path: every granted lane transaction, read or write, returns exactly one n_r_valid_i on that lane. Lane i pushes n_r_data_i[i] into its FIFO.
- Lane ready: n_r_ready_o is tied to 1. Credit gating guarantees the FIFO cannot overflow.
- Wide response: w_r_valid_o = all lane FIFOs non-empty. w_r_data_o is the concatenation of the FIFO heads, lane 0 in the LSBs. w_r_id_o is the ID FIFO head.
- Wide pop: occurs on w_r_valid_o & w_r_ready_i and pops all lane FIFOs plus the ID FIFO.
- Response latency: FIFOs are registered. A lane response in cycle N is visible at w_r_valid_o in cycle N+1 at the earliest. Push and pop on the same FIFO in the same cycle is legal and leaves occupancy unchanged.
- Boundary, outstanding = DEPTH: n_req_o and w_gnt_o are held 0 until a pop. On the pop cycle can_issue is still evaluated on the registered count, so no combinational bypass.
- clear_i flushes done bits, counter, FIFOs and err_o in one cycle. In-flight lane responses arriving after the clear are dropped and must not raise err_o for 1 cycle. Software only asserts clear_i when idle.
- Reset mid-operation: state is discarded; pending lane responses are the cluster's responsibility.

Optional Feature:
- Macro: SOFTEX_TCDM_LANE_SPLITTER_ERR_EN.
- Defined: each lane keeps a pending counter (+1 on lane grant, -1 on n_r_valid_i). err_o sets sticky when n_r_valid_i[i] arrives with pending = 0, or when a lane FIFO push occurs while that FIFO is full. err_o clears only on reset or clear_i.
- Undefined: no pending counters are built and err_o is tied to 0.

Test Plan:
- All lanes granted in the same cycle, w_add_i = 0x1000, MP = 4 -> n_add_o = 0x1000/0x1020/0x1040/0x1060; w_gnt_o = 1 in the same cycle.
- Staggered grants (lane 2 in cycle 0, lanes 0/1 in cycle 1, lane 3 in cycle 3) -> each n_req_o[i] drops the cycle after its grant; w_gnt_o pulses exactly once, in cycle 3.
- Read, w_id_i = 0x5A; lane responses arrive in cycles 5, 7, 6, 9 with data 0x11.., 0x22.., 0x33.., 0x44.. -> w_r_valid_o in cycle 10; w_r_data_o = {0x44..,0x33..,0x22..,0x11..}; w_r_id_o = 0x5A.
- Three back-to-back requests, DEPTH = 2, w_r_ready_i = 0 -> third request sees n_req_o = 0 and no grant until the first wide pop; responses come out in issue order.
- clear_i asserted with outstanding = 1 -> counter = 0; w_r_valid_o = 0 the next cycle; a new request is granted normally.
- With ERR_EN defined: n_r_valid_i[1] pulsed while idle -> err_o = 1 from the next cycle and stays set until clear_i.
